// File: rtl/tls_monitor.sv
// Passive traffic-light bus monitor: tracks the lit phase and reports phase durations.
// It also counts G->Y->R->G cycles and jumps into red, and flags illegal lamp patterns.
module tls_monitor #(
  parameter int CW = 8,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          g_in,
  input  logic          y_in,
  input  logic          r_in,
  output logic [1:0]    cur_phase,
  output logic          dur_valid,
  output logic [1:0]    dur_phase,
  output logic [CW-1:0] dur_val,
  output logic          dur_sat,
  output logic [NW-1:0] cycles,
  output logic [NW-1:0] jumps,
  output logic          err_multi,
  output logic          err_dark
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PG   = 2'd1;
  localparam logic [1:0] PY   = 2'd2;
  localparam logic [1:0] PR   = 2'd3;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [NW-1:0] NW_ONE  = {{(NW-1){1'b0}}, 1'b1};

  logic [1:0]    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          sat_r, sat_s;
  logic [1:0]    seq_r, seq_s;
  logic [2:0]    lamps_s;
  logic [1:0]    samp_ph_s;
  logic          samp_dark_s;
  logic          enter_s, report_s, cyc_inc_s, jmp_inc_s, set_multi_s, set_dark_s;

  assign lamps_s   = {g_in, y_in, r_in};
  assign cur_phase = state_r;

  // Classify the lamp sample; samp_ph_s is zero for DARK and MULTI.
  always_comb begin
    samp_ph_s   = IDLE;
    samp_dark_s = 1'b0;
    case (lamps_s)
      3'b100:  samp_ph_s   = PG;
      3'b010:  samp_ph_s   = PY;
      3'b001:  samp_ph_s   = PR;
      3'b000:  samp_dark_s = 1'b1;
      default: samp_ph_s   = IDLE;
    endcase
  end

  // Phase FSM, duration counter and G->Y->R->G sequence tracking.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    sat_s       = sat_r;
    seq_s       = seq_r;
    enter_s     = 1'b0;
    report_s    = 1'b0;
    cyc_inc_s   = 1'b0;
    jmp_inc_s   = 1'b0;
    set_multi_s = 1'b0;
    set_dark_s  = 1'b0;
    if (state_r == IDLE) begin
      if (samp_ph_s != IDLE) begin
        enter_s = 1'b1;
      end else begin
        set_multi_s = ~samp_dark_s;
      end
    end else if (samp_ph_s == state_r) begin
      if (cnt_r != CNT_MAX) begin
        cnt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_s = cnt_r;
      end
      sat_s = sat_r | (cnt_s == CNT_MAX);
    end else if (samp_ph_s != IDLE) begin
      report_s = 1'b1;
      enter_s  = 1'b1;
    end else if (samp_dark_s) begin
      set_dark_s = 1'b1;
    end else begin
      set_multi_s = 1'b1;
    end

    // A faulty sample while lit holds state, count and seq untouched.
    if (enter_s) begin
      state_s = samp_ph_s;
      cnt_s   = CNT_ONE;
      sat_s   = 1'b0;
      case (samp_ph_s)
        PG: begin
          cyc_inc_s = (state_r == PR) && (seq_r == 2'd3);
          seq_s     = 2'd1;
        end
        PY: seq_s = ((state_r == PG) && (seq_r == 2'd1)) ? 2'd2 : 2'd0;
        PR: begin
          seq_s     = ((state_r == PY) && (seq_r == 2'd2)) ? 2'd3 : 2'd0;
          jmp_inc_s = (state_r != PY);
        end
        default: seq_s = 2'd0;
      endcase
    end else begin
      seq_s = seq_r;
    end
  end

  // State and output registers; clr overrides counter increments and error sets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      sat_r     <= 1'b0;
      seq_r     <= 2'd0;
      dur_valid <= 1'b0;
      dur_phase <= 2'd0;
      dur_val   <= '0;
      dur_sat   <= 1'b0;
      cycles    <= '0;
      jumps     <= '0;
      err_multi <= 1'b0;
      err_dark  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      sat_r     <= sat_s;
      seq_r     <= seq_s;
      dur_valid <= report_s;
      if (report_s) begin
        dur_phase <= state_r;
        dur_val   <= cnt_r;
        dur_sat   <= sat_r;
      end else begin
        dur_phase <= dur_phase;
        dur_val   <= dur_val;
        dur_sat   <= dur_sat;
      end
      if (clr) begin
        cycles    <= '0;
        jumps     <= '0;
        err_multi <= 1'b0;
        err_dark  <= 1'b0;
      end else begin
        cycles    <= cyc_inc_s ? cycles + NW_ONE : cycles;
        jumps     <= jmp_inc_s ? jumps + NW_ONE : jumps;
        err_multi <= err_multi | set_multi_s;
        err_dark  <= err_dark | set_dark_s;
      end
    end
  end

endmodule

// File: tb/tb_tls_monitor.sv
// Self-checking bench for tls_monitor: vector table, directed corner sequences,
// and random lamp traffic against a phase-history reference model.
module tb_tls_monitor;

  logic        clk = 1'b0;
  logic        reset, clr, g_in, y_in, r_in;
  logic [1:0]  cur_phase, dur_phase;
  logic        dur_valid, dur_sat, err_multi, err_dark;
  logic [7:0]  dur_val;
  logic [15:0] cycles, jumps;

  tls_monitor #(.CW(8), .NW(16)) dut (
    .clk(clk), .reset(reset), .clr(clr), .g_in(g_in), .y_in(y_in), .r_in(r_in),
    .cur_phase(cur_phase), .dur_valid(dur_valid), .dur_phase(dur_phase),
    .dur_val(dur_val), .dur_sat(dur_sat), .cycles(cycles), .jumps(jumps),
    .err_multi(err_multi), .err_dark(err_dark)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase, run length, and the list of recent phase entries.
  int m_phase, m_count, m_dphase, m_dval, m_cycles, m_jumps;
  bit m_valid, m_dsat, m_emulti, m_edark;
  int hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_count = 0; m_dphase = 0; m_dval = 0;
    m_cycles = 0; m_jumps = 0;
    m_valid = 0; m_dsat = 0; m_emulti = 0; m_edark = 0;
    hist.delete();
  endtask

  task automatic model_enter(input int ph);
    if (ph == 3 && (hist.size() == 0 || hist[hist.size()-1] != 2))
      m_jumps = (m_jumps + 1) % 65536;
    hist.push_back(ph);
    if (hist.size() > 4) hist.delete(0);
    if (hist.size() == 4 && hist[0] == 1 && hist[1] == 2 && hist[2] == 3 && hist[3] == 1)
      m_cycles = (m_cycles + 1) % 65536;
    m_phase = ph;
    m_count = 1;
  endtask

  task automatic model_step(input logic [2:0] l, input logic c);
    int ph;
    ph = (l == 3'b100) ? 1 : (l == 3'b010) ? 2 : (l == 3'b001) ? 3 : 0;
    m_valid = 0;
    if (m_phase == 0) begin
      if (ph != 0) model_enter(ph);
      else if (l != 3'b000) m_emulti = 1;
    end else if (ph == m_phase) begin
      m_count++;
    end else if (ph != 0) begin
      m_valid  = 1;
      m_dphase = m_phase;
      m_dval   = (m_count > 255) ? 255 : m_count;
      m_dsat   = (m_count >= 255);
      model_enter(ph);
    end else if (l == 3'b000) begin
      m_edark = 1;
    end else begin
      m_emulti = 1;
    end
    if (c) begin
      m_cycles = 0; m_jumps = 0; m_emulti = 0; m_edark = 0;
    end
  endtask

  task automatic compare_model();
    chk("cur_phase", cur_phase, m_phase);
    chk("dur_valid", dur_valid, m_valid);
    chk("dur_phase", dur_phase, m_dphase);
    chk("dur_val",   dur_val,   m_dval);
    chk("dur_sat",   dur_sat,   m_dsat);
    chk("cycles",    cycles,    m_cycles);
    chk("jumps",     jumps,     m_jumps);
    chk("err_multi", err_multi, m_emulti);
    chk("err_dark",  err_dark,  m_edark);
  endtask

  // Drive one sample, clock it in, then check 1 time unit after the edge.
  task automatic step(input logic [2:0] l, input logic c);
    {g_in, y_in, r_in} = l;
    clr = c;
    @(posedge clk);
    model_step(l, c);
    #1;
    compare_model();
  endtask

  task automatic repeat_step(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) step(l, 1'b0);
  endtask

  // Asynchronous reset mid-cycle: outputs must be zero before the next edge.
  task automatic do_reset();
    {g_in, y_in, r_in} = 3'b000;
    clr = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_model();
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  lamps;
    logic        clr;
    logic [1:0]  ph;
    logic        v;
    logic [1:0]  dp;
    logic [7:0]  dv;
    logic [15:0] cyc;
    logic [15:0] jmp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [2:0] l, logic [1:0] ph, logic v, logic [1:0] dp,
                              logic [7:0] dv, logic [15:0] cyc);
    vec_t t;
    t.lamps = l; t.clr = 1'b0; t.ph = ph; t.v = v; t.dp = dp; t.dv = dv;
    t.cyc = cyc; t.jmp = 16'd0;
    return t;
  endfunction

  initial begin
    logic [2:0] cur_l, l;
    int r;
    reset = 1'b1;
    clr = 1'b0;
    {g_in, y_in, r_in} = 3'b000;
    model_reset();
    #12;
    compare_model();
    reset = 1'b0;

    // Nominal cycle: dark, G x5, Y x2, R x4, G, G.
    tbl.push_back(mk(3'b000, 2'd0, 1'b0, 2'd0, 8'd0, 16'd0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(3'b100, 2'd1, 1'b0, 2'd0, 8'd0, 16'd0));
    tbl.push_back(mk(3'b010, 2'd2, 1'b1, 2'd1, 8'd5, 16'd0));
    tbl.push_back(mk(3'b010, 2'd2, 1'b0, 2'd1, 8'd5, 16'd0));
    tbl.push_back(mk(3'b001, 2'd3, 1'b1, 2'd2, 8'd2, 16'd0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(3'b001, 2'd3, 1'b0, 2'd2, 8'd2, 16'd0));
    tbl.push_back(mk(3'b100, 2'd1, 1'b1, 2'd3, 8'd4, 16'd1));
    tbl.push_back(mk(3'b100, 2'd1, 1'b0, 2'd3, 8'd4, 16'd1));
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].lamps, tbl[i].clr);
      chk("tbl_phase", cur_phase, tbl[i].ph);
      chk("tbl_valid", dur_valid, tbl[i].v);
      chk("tbl_dphase", dur_phase, tbl[i].dp);
      chk("tbl_dval", dur_val, tbl[i].dv);
      chk("tbl_dsat", dur_sat, 1'b0);
      chk("tbl_cycles", cycles, tbl[i].cyc);
      chk("tbl_jumps", jumps, tbl[i].jmp);
      chk("tbl_errs", {err_multi, err_dark}, 2'b00);
    end

    // Jump G -> R; the following R -> G must not count a cycle.
    do_reset();
    repeat_step(3'b100, 3);
    step(3'b001, 1'b0);
    chk("jump_dval", dur_val, 8'd3);
    chk("jump_dphase", dur_phase, 2'd1);
    chk("jump_count", jumps, 16'd1);
    step(3'b001, 1'b0);
    step(3'b100, 1'b0);
    chk("jump_cycles", cycles, 16'd0);
    chk("jump_dval_r", dur_val, 8'd2);

    // Saturation boundary: 254 is unsaturated, 300 clamps to 255.
    do_reset();
    repeat_step(3'b100, 254);
    step(3'b010, 1'b0);
    chk("sat254_dval", dur_val, 8'd254);
    chk("sat254_sat", dur_sat, 1'b0);
    repeat_step(3'b100, 300);
    step(3'b010, 1'b0);
    chk("sat300_dval", dur_val, 8'd255);
    chk("sat300_sat", dur_sat, 1'b1);
    chk("sat300_dphase", dur_phase, 2'd1);

    // MULTI during Y is flagged, not counted, and does not leave Y.
    do_reset();
    step(3'b100, 1'b0);
    step(3'b010, 1'b0);
    step(3'b110, 1'b0);
    chk("multi_phase", cur_phase, 2'd2);
    chk("multi_flag", err_multi, 1'b1);
    repeat_step(3'b010, 2);
    step(3'b001, 1'b0);
    chk("multi_dval", dur_val, 8'd3);
    chk("multi_dphase", dur_phase, 2'd2);

    // DARK during R, then clr coinciding with a cycle completion.
    do_reset();
    step(3'b100, 1'b0);
    step(3'b010, 1'b0);
    step(3'b001, 1'b0);
    step(3'b000, 1'b0);
    chk("dark_flag", err_dark, 1'b1);
    chk("dark_phase", cur_phase, 2'd3);
    step(3'b001, 1'b0);
    step(3'b100, 1'b0);
    chk("dark_cycles", cycles, 16'd1);
    step(3'b010, 1'b0);
    step(3'b001, 1'b0);
    step(3'b100, 1'b1);
    chk("clr_cycles", cycles, 16'd0);
    chk("clr_dark", err_dark, 1'b0);

    // Reset mid-R drops the pending report.
    do_reset();
    step(3'b100, 1'b0);
    step(3'b010, 1'b0);
    repeat_step(3'b001, 2);
    do_reset();
    step(3'b100, 1'b0);
    chk("rst_valid", dur_valid, 1'b0);
    chk("rst_phase", cur_phase, 2'd1);

    // Random traffic against the reference model.
    do_reset();
    cur_l = 3'b100;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) l = cur_l;
      else if (r < 88) begin
        case ($urandom_range(0, 2))
          0: cur_l = 3'b100;
          1: cur_l = 3'b010;
          default: cur_l = 3'b001;
        endcase
        l = cur_l;
      end
      else if (r < 93) l = 3'b000;
      else l = 3'($urandom_range(0, 7));
      if (i == 2000 || $urandom_range(0, 499) == 0) do_reset();
      else step(l, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tls_monitor.md
# tls_monitor

Passive observer on the traffic-light output bus (Gout/Yout/Rout) of the light controller. It samples the three lamp lines every clock and tracks the current phase. On each phase change it reports the measured duration of the completed phase. It also counts complete G→Y→R→G cycles and jump entries into red, and raises sticky error flags for illegal lamp patterns. It sits beside the controller and feeds status/debug registers; it never drives the lamps.

## Interface
- CW, 8, width of duration counter and dur_val
- NW, 16, width of cycles and jumps counters
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; all state and outputs to reset values
- clr  in  1  synchronous clear of cycles, jumps, err_multi, err_dark
- g_in  in  1  green lamp line
- y_in  in  1  yellow lamp line
- r_in  in  1  red lamp line
- cur_phase  out  2  registered current phase: 0 none, 1 G, 2 Y, 3 R
- dur_valid  out  1  one-cycle pulse: a phase just completed
- dur_phase  out  2  phase code of the completed phase, held until next report
- dur_val  out  CW  samples the completed phase was lit, held until next report
- dur_sat  out  1  duration counter saturated during the reported phase
- cycles  out  NW  completed G→Y→R→G sequences, wraps modulo 2^NW
- jumps  out  NW  entries into R not from Y, wraps modulo 2^NW
- err_multi  out  1  sticky: more than one lamp lit in a sample
- err_dark  out  1  sticky: no lamp lit after the first lit sample

## Operation
- Each clock, classify the sample {g_in,y_in,r_in}:
  - G = 100, Y = 010, R = 001.
  - DARK = 000.
  - MULTI = any pattern with two or more bits set.
- FSM states: IDLE (cur_phase=0), PG, PY, PR. Reset enters IDLE.
- IDLE:
  - DARK: stay, no error.
  - G/Y/R: enter that phase, cnt=1, no report.
  - MULTI: set err_multi, stay.
- In a phase, sample equals current phase: cnt = cnt+1, saturating at 2^CW−1. Set the internal sat flag when the saturated value is reached.
- In a phase, sample is a different legal phase:
  - dur_val=cnt, dur_phase=old phase, dur_sat=sat flag, dur_valid=1.
  - Enter the new phase with cnt=1 and sat flag cleared.
- In a phase, sample is DARK or MULTI:
  - Set err_dark or err_multi respectively.
  - State, cnt and sat flag are held; the sample is not counted.
- Sequence tracker seq (2 bits):
  - Any entry into G sets seq=1.
  - G→Y with seq=1 sets seq=2.
  - Y→R with seq=2 sets seq=3.
  - Any other transition sets seq=0.
  - R→G with seq=3 increments cycles; seq then becomes 1.
- Entry into R from G or IDLE increments jumps.
- clr:
  - Zeroes cycles and jumps and clears both error flags.
  - Wins over a same-cycle increment or error set.
  - Does not affect FSM state, cnt, seq or dur_* outputs.
- Counters wrap; only cnt saturates.

## Timing
- All outputs are registered. An input sampled at edge N is reflected at edge N (visible after N).
- dur_valid is high for exactly one cycle, in the cycle after the edge that sampled the new phase.
- dur_phase, dur_val and dur_sat update only with dur_valid and hold otherwise.
- Reset value of every output is 0. Reset asserted mid-phase drops any pending report; no dur_valid is issued.
- Back-to-back phase changes on consecutive edges each produce a dur_valid pulse, with dur_val=1.
- Lamp inputs are synchronous to clk; no synchronizer is present.

## Test plan
- Reset, 1 dark cycle, then G×5, Y×2, R×4, G → dur_valid pulses report (1,5), (2,2), (3,4); cycles=1, jumps=0, no errors.
- G×3 then R (jump) → report (1,3); jumps=1; at next R→G, cycles stays 0.
- With CW=8, G held 300 samples then Y → dur_val=255, dur_sat=1, dur_phase=1.
- During Y, sample 110 for 1 cycle then Y continues for 2 more samples then R → err_multi=1; dur_val=3 (MULTI not counted); cur_phase stays 2 through the fault.
- During R, one DARK sample → err_dark=1; then assert clr together with a G→Y→R→G completion → err_dark=0 and cycles=0 afterward.
- Reset asserted mid-R after 2 samples → all outputs 0 immediately. The next G sample enters PG with no dur_valid.
